// File: rtl/host_fifo_pkg.sv
// Shared definitions for the host FIFO word, used by the writer and the host-side reader.
package host_fifo_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned BUF_W  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FIFO_W = BUF_W + LEN_W + 2 + DATA_W;

    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned EOP_BIT  = DATA_W;
    localparam int unsigned SOP_BIT  = DATA_W + 1;
    localparam int unsigned LEN_LSB  = DATA_W + 2;
    localparam int unsigned BUF_LSB  = DATA_W + 2 + LEN_W;

    typedef struct packed {
        logic [BUF_W-1:0]  buffer;
        logic [LEN_W-1:0]  length;
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } host_fifo_word_t;

    typedef enum logic [0:0] {IDLE, IN_PKT} framer_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/host_fifo_writer_if.sv
// Beat-in / FIFO-write bundle between the packet parser, the writer and the host FIFO.
interface host_fifo_writer_if;
    import host_fifo_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic [LEN_W-1:0]  in_length;
    logic              fifo_full;
    logic              wr_en;
    logic [FIFO_W-1:0] fifo_data;

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_length, fifo_full,
        input  in_ready, wr_en, fifo_data
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_length, fifo_full,
        output in_ready, wr_en, fifo_data
    );

endinterface

// File: rtl/fifo_skid_reg.sv
// Two-entry register stage (OUT + SKID) with registered upstream ready; order preserving.
module fifo_skid_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;
    logic             drain, push;

    always_comb begin
        drain        = out_valid_q && out_ready_i;
        push         = in_valid_i && in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = push;
                if (push) skid_data_d = in_data_i;
            end else begin
                out_valid_d = push;
                if (push) out_data_d = in_data_i;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/host_fifo_writer.sv
// Host FIFO write side: frames parser beats, stamps buffer ids, packs words and counts events.
module host_fifo_writer
    import host_fifo_pkg::*;
(
    input  logic             clk_net,
    input  logic             rst,
    host_fifo_writer_if.slave bus,
    output logic             in_packet,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    framer_state_e    state_q, state_d;
    logic [BUF_W-1:0] next_id_q, next_id_d;
    logic [BUF_W-1:0] cur_id_q, cur_id_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             ready, accept, push, out_ready, out_valid;
    host_fifo_word_t  word;
    logic [FIFO_W-1:0] out_data;

    assign accept    = bus.in_valid && ready;
    assign out_ready = !bus.fifo_full;

    always_comb begin
        state_d     = state_q;
        next_id_d   = next_id_q;
        cur_id_d    = cur_id_q;
        pkt_d       = pkt_q;
        err_d       = err_q;
        push        = 1'b0;
        word.buffer = cur_id_q;
        word.length = bus.in_eop ? bus.in_length : '0;
        word.sop    = bus.in_sop;
        word.eop    = bus.in_eop;
        word.data   = bus.in_data;
        if (accept) begin
            if (bus.in_sop) begin
                // A sop inside a packet abandons the old one and opens a fresh id.
                if (state_q == IN_PKT) err_d = sat_inc(err_q);
                word.buffer = next_id_q;
                cur_id_d    = next_id_q;
                next_id_d   = next_id_q + BUF_W'(1);
                push        = 1'b1;
                state_d     = bus.in_eop ? IDLE : IN_PKT;
                if (bus.in_eop) pkt_d = sat_inc(pkt_q);
            end else if (state_q == IDLE) begin
                err_d = sat_inc(err_q);
            end else begin
                push = 1'b1;
                if (bus.in_eop) begin
                    state_d = IDLE;
                    pkt_d   = sat_inc(pkt_q);
                end
            end
        end
    end

    always_ff @(posedge clk_net) begin
        if (rst) begin
            state_q   <= IDLE;
            next_id_q <= '0;
            cur_id_q  <= '0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            next_id_q <= next_id_d;
            cur_id_q  <= cur_id_d;
            pkt_q     <= pkt_d;
            err_q     <= err_d;
        end
    end

    fifo_skid_reg #(
        .Width(FIFO_W)
    ) u_skid (
        .clk_i      (clk_net),
        .rst_i      (rst),
        .in_valid_i (push),
        .in_data_i  (word),
        .in_ready_o (ready),
        .out_ready_i(out_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data)
    );

    assign bus.in_ready  = ready;
    assign bus.wr_en     = out_valid && out_ready;
    assign bus.fifo_data = out_data;
    assign in_packet     = (state_q == IN_PKT);
    assign pkt_count     = pkt_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_host_fifo_writer.sv
// Bench for host_fifo_writer: directed vector table, corner sequences and a random run vs a queue model.
module tb_host_fifo_writer;
    import host_fifo_pkg::*;

    logic             clk_net = 1'b0;
    logic             rst = 1'b1;
    logic             in_packet;
    logic [CNT_W-1:0] pkt_count, err_count;

    host_fifo_writer_if bus();

    host_fifo_writer dut (
        .clk_net  (clk_net),
        .rst      (rst),
        .bus      (bus),
        .in_packet(in_packet),
        .pkt_count(pkt_count),
        .err_count(err_count)
    );

    always #5 clk_net = ~clk_net;

    int checks = 0;
    int errors = 0;

    // Reference model: words still owed to the FIFO, framing flag, id and event counts.
    host_fifo_word_t exp_q[$];
    bit              m_in_pkt;
    int              m_next_id, m_cur_id, m_pkt, m_err;

    bit              obs_wr, obs_rdy;
    host_fifo_word_t obs_data;

    typedef struct {
        bit              v, s, e;
        logic [2:0]      len;
        logic [63:0]     d;
        bit              exp_wr;
        host_fifo_word_t exp_w;
    } vec_t;
    vec_t tv[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    function automatic void model_beat(input bit s, input bit e, input logic [2:0] len,
                                       input logic [63:0] d);
        host_fifo_word_t w;
        bit wr = 1'b1;
        if (s) begin
            if (m_in_pkt) m_err = sat(m_err);
            m_cur_id  = m_next_id;
            m_next_id = (m_next_id + 1) % 256;
            m_in_pkt  = !e;
        end else if (!m_in_pkt) begin
            m_err = sat(m_err);
            wr    = 1'b0;
        end else if (e) begin
            m_in_pkt = 1'b0;
        end
        if (wr && e) m_pkt = sat(m_pkt);
        w.buffer = 8'(m_cur_id);
        w.length = e ? len : 3'd0;
        w.sop    = s;
        w.eop    = e;
        w.data   = d;
        if (wr) exp_q.push_back(w);
    endfunction

    task automatic cycle(input bit v, input bit s, input bit e, input logic [2:0] len,
                         input logic [63:0] d, input bit full, output bit acc);
        bit exp_rdy;
        bus.in_valid  = v;
        bus.in_sop    = s;
        bus.in_eop    = e;
        bus.in_length = len;
        bus.in_data   = d;
        bus.fifo_full = full;
        #1;
        obs_wr   = bus.wr_en;
        obs_rdy  = bus.in_ready;
        obs_data = bus.fifo_data;
        exp_rdy  = exp_q.size() < 2;
        chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
        chk("wr_en", 128'(bus.wr_en), 128'(exp_q.size() > 0 && !full));
        if (exp_q.size() > 0) chk("fifo_data", 128'(bus.fifo_data), 128'(exp_q[0]));
        chk("in_packet", 128'(in_packet), 128'(m_in_pkt));
        chk("pkt_count", 128'(pkt_count), 128'(m_pkt));
        chk("err_count", 128'(err_count), 128'(m_err));
        acc = v && exp_rdy;
        if (exp_q.size() > 0 && !full) void'(exp_q.pop_front());
        if (acc) model_beat(s, e, len, d);
        @(negedge clk_net);
    endtask

    task automatic send(input bit s, input bit e, input logic [2:0] len, input logic [63:0] d,
                        input bit full);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, s, e, len, d, full, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept for data %0h", d);
        end
    endtask

    task automatic idle(input int n, input bit full);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, full, acc);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.fifo_full = 1'b0;
        rst = 1'b1;
        @(posedge clk_net);
        #1;
        chk("rst_wr_en", 128'(bus.wr_en), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_fifo_data", 128'(bus.fifo_data), 128'(0));
        chk("rst_in_packet", 128'(in_packet), 128'(0));
        chk("rst_pkt_count", 128'(pkt_count), 128'(0));
        chk("rst_err_count", 128'(err_count), 128'(0));
        exp_q.delete();
        m_in_pkt = 1'b0;
        m_next_id = 0;
        m_cur_id = 0;
        m_pkt = 0;
        m_err = 0;
        @(negedge clk_net);
        rst = 1'b0;
        @(negedge clk_net);
        chk("in_ready_after_rst", 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        bit acc;
        int idx;
        logic [63:0] sd[7];

        tv[0] = '{v:1, s:1, e:0, len:3'd0, d:64'hA0, exp_wr:0, exp_w:'0};
        tv[1] = '{v:1, s:0, e:0, len:3'd0, d:64'hB1, exp_wr:1,
                  exp_w:'{buffer:8'd0, length:3'd0, sop:1'b1, eop:1'b0, data:64'hA0}};
        tv[2] = '{v:1, s:0, e:1, len:3'd5, d:64'hC2, exp_wr:1,
                  exp_w:'{buffer:8'd0, length:3'd0, sop:1'b0, eop:1'b0, data:64'hB1}};
        tv[3] = '{v:0, s:0, e:0, len:3'd0, d:64'h0, exp_wr:1,
                  exp_w:'{buffer:8'd0, length:3'd5, sop:1'b0, eop:1'b1, data:64'hC2}};
        tv[4] = '{v:0, s:0, e:0, len:3'd0, d:64'h0, exp_wr:0, exp_w:'0};

        bus.in_valid = 1'b0;
        bus.in_sop = 1'b0;
        bus.in_eop = 1'b0;
        bus.in_length = '0;
        bus.in_data = '0;
        bus.fifo_full = 1'b0;
        do_reset();

        // 3-beat packet, back-to-back writes
        for (int i = 0; i < 5; i++) begin
            cycle(tv[i].v, tv[i].s, tv[i].e, tv[i].len, tv[i].d, 1'b0, acc);
            chk($sformatf("tv%0d_wr", i), 128'(obs_wr), 128'(tv[i].exp_wr));
            if (tv[i].exp_wr) chk($sformatf("tv%0d_word", i), 128'(obs_data), 128'(tv[i].exp_w));
        end
        chk("tv_pkt_count", 128'(pkt_count), 128'(1));

        // fifo_full held 5 cycles with beats offered every cycle
        do_reset();
        for (int i = 0; i < 7; i++) sd[i] = 64'h1000 + 64'(i);
        send(1'b1, 1'b0, 3'd0, sd[0], 1'b0);
        idx = 1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 3'd0, sd[idx], 1'b1, acc);
            chk("stall_hold", 128'(obs_data.data), 128'(sd[0]));
            if (acc) idx++;
        end
        chk("stall_accepted", 128'(idx), 128'(2));
        chk("stall_in_ready", 128'(obs_rdy), 128'(0));
        for (int i = 2; i < 7; i++) send(1'b0, i == 6, 3'd2, sd[i], 1'b0);
        idle(4, 1'b0);
        chk("stall_drained", 128'(exp_q.size()), 128'(0));
        chk("stall_pkt_count", 128'(pkt_count), 128'(1));

        // 260 single-beat packets: id wraps after 255
        do_reset();
        for (int i = 0; i < 260; i++) send(1'b1, 1'b1, 3'(i), 64'(i), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0, acc);
        chk("wrap_last_buffer", 128'(obs_data.buffer), 128'(3));
        idle(1, 1'b0);
        chk("wrap_pkt_count", 128'(pkt_count), 128'(260));

        // beat without sop while idle is dropped
        do_reset();
        send(1'b0, 1'b0, 3'd0, 64'hDEAD, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0, acc);
        chk("nosop_no_write", 128'(obs_wr), 128'(0));
        chk("nosop_err_count", 128'(err_count), 128'(1));
        send(1'b1, 1'b1, 3'd4, 64'hBEEF, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0, acc);
        chk("nosop_next_wr", 128'(obs_wr), 128'(1));
        chk("nosop_next_word", 128'(obs_data),
            128'(host_fifo_word_t'{buffer:8'd0, length:3'd4, sop:1'b1, eop:1'b1, data:64'hBEEF}));

        // sop inside a packet
        do_reset();
        send(1'b1, 1'b0, 3'd0, 64'h11, 1'b0);
        send(1'b1, 1'b0, 3'd0, 64'h22, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0, acc);
        chk("resop_word", 128'(obs_data),
            128'(host_fifo_word_t'{buffer:8'd1, length:3'd0, sop:1'b1, eop:1'b0, data:64'h22}));
        chk("resop_err_count", 128'(err_count), 128'(1));
        chk("resop_in_packet", 128'(in_packet), 128'(1));

        // reset with OUT and SKID both occupied
        do_reset();
        send(1'b1, 1'b0, 3'd0, 64'h31, 1'b1);
        send(1'b0, 1'b0, 3'd0, 64'h32, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b1, acc);
        chk("prerst_full", 128'(obs_rdy), 128'(0));
        do_reset();
        send(1'b1, 1'b1, 3'd1, 64'h41, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b0, acc);
        chk("postrst_buffer", 128'(obs_data.buffer), 128'(0));

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, 3'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 3) == 0, acc);
        end
        idle(4, 1'b0);
        chk("random_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
